// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types and constants for the pipeline hazard unit
package cpu_types_pkg;

   localparam int COUNT_W = 16;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      HALT  = 2'd2
   } hazard_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-high clear
module sat_counter #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;
   logic         w_at_max;

   assign w_at_max = (r_count == {W{1'b1}});

   // count up on request, holding at all-ones instead of wrapping
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_inc && !w_at_max) begin
         r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline stall/flush control with memory wait and halt handling
module hazard_unit
   import cpu_types_pkg::*;
(
   input  logic               CLK,
   input  logic               RST,
   input  logic               ihit,
   input  logic               dhit,
   input  logic               exmem_dREN,
   input  logic               exmem_dWEN,
   input  logic               idex_dREN,
   input  logic [4:0]         idex_Rt,
   input  logic [4:0]         ifid_Rs,
   input  logic [4:0]         ifid_Rt,
   input  logic               ifid_usesRt,
   input  logic               branch_taken,
   input  logic               jump,
   input  logic               halt,
   output logic               pc_en,
   output logic               ifid_en,
   output logic               ifid_flush,
   output logic               idex_en,
   output logic               idex_flush,
   output logic               exmem_en,
   output logic               memwb_en,
   output logic               halted,
   output logic [COUNT_W-1:0] stall_cnt,
   output logic [COUNT_W-1:0] flush_cnt
);

   hazard_state_t r_state;
   hazard_state_t w_state_next;
   logic          r_flush_pend;
   logic          w_pend_next;
   logic          w_dmem_busy;
   logic          w_advance;
   logic          w_load_use;
   logic          w_want_flush;
   logic          w_stall_inc;
   logic          w_flush_inc;

   assign w_dmem_busy  = (exmem_dREN | exmem_dWEN) & ~dhit;
   assign w_advance    = ihit & ~w_dmem_busy;
   // register 0 is hardwired, so a load targeting it never creates a dependency
   assign w_load_use   = idex_dREN && (idex_Rt != 5'd0) &&
                         ((idex_Rt == ifid_Rs) || (ifid_usesRt && (idex_Rt == ifid_Rt)));
   assign w_want_flush = branch_taken | r_flush_pend;

   // next-state and pipeline control; a branch flush outranks load-use and jump
   always_comb begin
      w_state_next = r_state;
      w_pend_next  = r_flush_pend;
      w_stall_inc  = 1'b0;
      w_flush_inc  = 1'b0;
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      ifid_flush   = 1'b0;
      idex_en      = 1'b0;
      idex_flush   = 1'b0;
      exmem_en     = 1'b0;
      memwb_en     = 1'b0;
      if (!RST) begin
         case (r_state)
            RUN, DWAIT: begin
               if (w_advance) begin
                  pc_en    = 1'b1;
                  ifid_en  = 1'b1;
                  idex_en  = 1'b1;
                  exmem_en = 1'b1;
                  memwb_en = 1'b1;
                  if (w_want_flush) begin
                     ifid_flush  = 1'b1;
                     idex_flush  = 1'b1;
                     w_pend_next = 1'b0;
                     w_flush_inc = 1'b1;
                  end else if (w_load_use) begin
                     pc_en      = 1'b0;
                     ifid_en    = 1'b0;
                     idex_flush = 1'b1;
                  end else if (jump) begin
                     ifid_flush  = 1'b1;
                     w_flush_inc = 1'b1;
                  end
                  w_state_next = halt ? HALT : RUN;
               end else begin
                  // a branch resolved during a freeze must not be lost
                  if (branch_taken) begin
                     w_pend_next = 1'b1;
                  end
                  w_state_next = w_dmem_busy ? DWAIT : RUN;
               end
               w_stall_inc = ~pc_en;
            end
            HALT: begin
               w_state_next = HALT;
            end
            default: begin
               w_state_next = RUN;
            end
         endcase
      end
   end

   // state and pending-flush registers; reset overrides every other event
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= RUN;
         r_flush_pend <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_flush_pend <= w_pend_next;
      end
   end

   assign halted = (r_state == HALT);

   sat_counter #(.W(COUNT_W)) u_stall_cnt (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_inc   (w_stall_inc),
      .o_count (stall_cnt)
   );

   sat_counter #(.W(COUNT_W)) u_flush_cnt (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_inc   (w_flush_inc),
      .o_count (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN;
   logic [4:0]  idex_Rt, ifid_Rs, ifid_Rt;
   logic        ifid_usesRt, branch_taken, jump, halt;
   logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted;
   logic [15:0] stall_cnt, flush_cnt;
   logic [6:0]  ctl;

   int n_checks = 0;
   int n_fail   = 0;

   // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
   localparam logic [6:0] C_FREEZE = 7'b0000000;
   localparam logic [6:0] C_RUN    = 7'b1101011;
   localparam logic [6:0] C_LU     = 7'b0001111;
   localparam logic [6:0] C_BR     = 7'b1111111;
   localparam logic [6:0] C_JMP    = 7'b1111011;

   assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};

   always #5 CLK = ~CLK;

   hazard_unit dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
      .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
      .idex_dREN(idex_dREN), .idex_Rt(idex_Rt), .ifid_Rs(ifid_Rs), .ifid_Rt(ifid_Rt),
      .ifid_usesRt(ifid_usesRt), .branch_taken(branch_taken), .jump(jump), .halt(halt),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
      .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en),
      .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic idle_inputs();
      ihit = 1'b1; dhit = 1'b0; exmem_dREN = 1'b0; exmem_dWEN = 1'b0;
      idex_dREN = 1'b0; idex_Rt = 5'd0; ifid_Rs = 5'd0; ifid_Rt = 5'd0;
      ifid_usesRt = 1'b0; branch_taken = 1'b0; jump = 1'b0; halt = 1'b0;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      RST = 1'b1;
      step();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      RST = 1'b1;
      #1;
      n_checks++; if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_FREEZE); end
      step();
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
      n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
      n_checks++; if (flush_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_flush_cnt: got %0d expected 0", flush_cnt); end
      RST = 1'b0;
      #1;
      n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL post_reset_run: got %b expected %b", ctl, C_RUN); end
      ihit = 1'b0;
      #1;
      n_checks++; if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL ihit_miss_freeze: got %b expected %b", ctl, C_FREEZE); end
      step();
      n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL ihit_miss_stall_cnt: got %0d expected 1", stall_cnt); end
   endtask

   task automatic test_load_use();
      do_reset();
      idex_dREN = 1'b1; idex_Rt = 5'd5; ifid_Rs = 5'd5;
      #1;
      n_checks++; if (ctl !== C_LU) begin n_fail++; $display("FAIL load_use_ctl: got %b expected %b", ctl, C_LU); end
      step();
      n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL load_use_stall_cnt: got %0d expected 1", stall_cnt); end
      idex_dREN = 1'b0;
      #1;
      n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL load_use_release: got %b expected %b", ctl, C_RUN); end
      step();
      n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL load_use_stall_hold: got %0d expected 1", stall_cnt); end
   endtask

   task automatic test_rt_match();
      do_reset();
      idex_dREN = 1'b1; idex_Rt = 5'd0; ifid_Rs = 5'd0;
      #1;
      n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL rt_zero_exempt: got %b expected %b", ctl, C_RUN); end
      idex_Rt = 5'd7; ifid_Rs = 5'd3; ifid_Rt = 5'd7; ifid_usesRt = 1'b0;
      #1;
      n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL rt_unused_no_stall: got %b expected %b", ctl, C_RUN); end
      ifid_usesRt = 1'b1;
      #1;
      n_checks++; if (ctl !== C_LU) begin n_fail++; $display("FAIL rt_used_stall: got %b expected %b", ctl, C_LU); end
      step();
      n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL rt_used_stall_cnt: got %0d expected 1", stall_cnt); end
   endtask

   task automatic test_dmem_wait();
      do_reset();
      exmem_dREN = 1'b1; dhit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL dmem_wait_freeze[%0d]: got %b expected %b", i, ctl, C_FREEZE); end
         step();
      end
      dhit = 1'b1;
      #1;
      n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL dmem_hit_release: got %b expected %b", ctl, C_RUN); end
      step();
      n_checks++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL dmem_stall_cnt: got %0d expected 3", stall_cnt); end
      exmem_dWEN = 1'b1; exmem_dREN = 1'b0; dhit = 1'b0;
      step();
      step();
      n_checks++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL store_wait_stall_cnt: got %0d expected 5", stall_cnt); end
      RST = 1'b1;
      #1;
      n_checks++; if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL dwait_reset_ctl: got %b expected %b", ctl, C_FREEZE); end
      step();
      n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL dwait_reset_stall_cnt: got %0d expected 0", stall_cnt); end
      RST = 1'b0; exmem_dWEN = 1'b0;
      #1;
      n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL dwait_reset_run: got %b expected %b", ctl, C_RUN); end
   endtask

   task automatic test_branch_freeze();
      do_reset();
      exmem_dREN = 1'b1; dhit = 1'b0; branch_taken = 1'b1;
      #1;
      n_checks++; if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL branch_frozen: got %b expected %b", ctl, C_FREEZE); end
      step();
      branch_taken = 1'b0;
      #1;
      n_checks++; if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL branch_pend_frozen: got %b expected %b", ctl, C_FREEZE); end
      step();
      dhit = 1'b1;
      #1;
      n_checks++; if (ctl !== C_BR) begin n_fail++; $display("FAIL branch_pend_flush: got %b expected %b", ctl, C_BR); end
      step();
      n_checks++; if (flush_cnt !== 16'd1) begin n_fail++; $display("FAIL branch_pend_flush_cnt: got %0d expected 1", flush_cnt); end
      exmem_dREN = 1'b0; dhit = 1'b0;
      #1;
      n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL branch_pend_cleared: got %b expected %b", ctl, C_RUN); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      branch_taken = 1'b1; idex_dREN = 1'b1; idex_Rt = 5'd9; ifid_Rs = 5'd9;
      #1;
      n_checks++; if (ctl !== C_BR) begin n_fail++; $display("FAIL branch_over_load_use: got %b expected %b", ctl, C_BR); end
      step();
      n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL branch_lu_stall_cnt: got %0d expected 0", stall_cnt); end
      n_checks++; if (flush_cnt !== 16'd1) begin n_fail++; $display("FAIL branch_lu_flush_cnt: got %0d expected 1", flush_cnt); end
      branch_taken = 1'b0; idex_dREN = 1'b0; jump = 1'b1;
      #1;
      n_checks++; if (ctl !== C_JMP) begin n_fail++; $display("FAIL jump_ctl: got %b expected %b", ctl, C_JMP); end
      step();
      branch_taken = 1'b1;
      #1;
      n_checks++; if (ctl !== C_BR) begin n_fail++; $display("FAIL branch_over_jump: got %b expected %b", ctl, C_BR); end
      step();
      n_checks++; if (flush_cnt !== 16'd3) begin n_fail++; $display("FAIL jump_branch_flush_cnt: got %0d expected 3", flush_cnt); end
   endtask

   task automatic test_halt();
      do_reset();
      halt = 1'b1;
      #1;
      n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL halt_cycle_ctl: got %b expected %b", ctl, C_RUN); end
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_cycle_halted: got %b expected 0", halted); end
      step();
      halt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++; if (ctl !== C_FREEZE || halted !== 1'b1) begin n_fail++; $display("FAIL halted_hold[%0d]: got ctl=%b halted=%b expected ctl=%b halted=1", i, ctl, halted, C_FREEZE); end
         step();
      end
      n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL halted_stall_cnt: got %0d expected 0", stall_cnt); end
      RST = 1'b1;
      step();
      RST = 1'b0;
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset_halted: got %b expected 0", halted); end
      #1;
      n_checks++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL halt_reset_run: got %b expected %b", ctl, C_RUN); end
   endtask

   task automatic test_saturate();
      do_reset();
      ihit = 1'b0;
      repeat (65540) @(posedge CLK);
      #1;
      n_checks++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL stall_cnt_saturate: got %h expected ffff", stall_cnt); end
   endtask

   initial begin
      idle_inputs();
      RST = 1'b1;
      test_reset();
      test_load_use();
      test_rt_match();
      test_dmem_wait();
      test_branch_freeze();
      test_back_to_back();
      test_halt();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
